// File: rtl/dds_cfg_ctl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dds_cfg_ctl : serial NUM/DEN -> phase_step_h/l, modulo; atomic apply + settle
// Rev 1.0
// ---------------------------------------------------------------------------
module dds_cfg_ctl #(
  parameter int SETTLE_CYC = 21,
  parameter int SW         = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [11:0] cfg_num,
  input  logic [11:0] cfg_den,
  input  logic        cfg_start,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_err,
  output logic [19:0] phase_step_h,
  output logic [11:0] phase_step_l,
  output logic [11:0] modulo,
  output logic        acc_reset,
  output logic        data_valid
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REJECT = 3'd1,
    S_DIV_M  = 3'd2,
    S_DIV_H  = 3'd3,
    S_MUL_L  = 3'd4,
    S_APPLY  = 3'd5,
    S_SETTLE = 3'd6
  } state_t;

  localparam logic [4:0]    M_LAST      = 5'd11;
  localparam logic [4:0]    H_LAST      = 5'd19;
  localparam logic [4:0]    L_LAST      = 5'd11;
  localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE_CYC);
  localparam logic [SW-1:0] CNT_ONE     = SW'(1);

  state_t      state_q, state_d;
  logic [11:0] num_q, num_d;
  logic [11:0] den_q, den_d;
  logic [11:0] rem_q, rem_d;
  logic [19:0] quo_q, quo_d;
  logic [11:0] m_q, m_d;
  logic [11:0] mod_q, mod_d;
  logic [11:0] lacc_q, lacc_d;
  logic [4:0]  step_q, step_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [19:0] ph_h_q, ph_h_d;
  logic [11:0] ph_l_q, ph_l_d;
  logic [11:0] modulo_q, modulo_d;
  logic        acc_reset_q, acc_reset_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        legal;
  logic [12:0] div_sh;
  logic        div_ge;
  logic [11:0] div_rem;
  logic [11:0] mul_add;

  assign legal = (cfg_den >= 12'd2) && (cfg_num < cfg_den);

  // One restoring-divide step shared by DIV_M and DIV_H; when div_ge the
  // true difference is below DEN, so the low 12 bits of the subtraction suffice.
  assign div_sh  = {rem_q, 1'b0};
  assign div_ge  = (div_sh >= {1'b0, den_q});
  assign div_rem = div_ge ? (div_sh[11:0] - den_q) : div_sh[11:0];
  assign mul_add = m_q[11] ? rem_q : 12'd0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      num_q       <= '0;
      den_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      m_q         <= '0;
      mod_q       <= '0;
      lacc_q      <= '0;
      step_q      <= '0;
      cnt_q       <= '0;
      ph_h_q      <= '0;
      ph_l_q      <= '0;
      modulo_q    <= '0;
      acc_reset_q <= 1'b1;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      den_q       <= den_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      m_q         <= m_d;
      mod_q       <= mod_d;
      lacc_q      <= lacc_d;
      step_q      <= step_d;
      cnt_q       <= cnt_d;
      ph_h_q      <= ph_h_d;
      ph_l_q      <= ph_l_d;
      modulo_q    <= modulo_d;
      acc_reset_q <= acc_reset_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    den_d       = den_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    m_d         = m_q;
    mod_d       = mod_q;
    lacc_d      = lacc_q;
    step_d      = step_q;
    cnt_d       = cnt_q;
    ph_h_d      = ph_h_q;
    ph_l_d      = ph_l_q;
    modulo_d    = modulo_q;
    acc_reset_d = acc_reset_q;
    valid_d     = valid_q;
    done_d      = 1'b0;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          if (legal) begin
            num_d   = cfg_num;
            den_d   = cfg_den;
            err_d   = 1'b0;
            rem_d   = 12'd1;
            quo_d   = '0;
            step_d  = '0;
            state_d = S_DIV_M;
          end else begin
            err_d   = 1'b1;
            state_d = S_REJECT;
          end
        end
      end

      S_REJECT: state_d = S_IDLE;

      S_DIV_M: begin
        rem_d  = div_rem;
        quo_d  = {quo_q[18:0], div_ge};
        step_d = step_q + 5'd1;
        if (step_q == M_LAST) begin
          // Capture m and modulo, then seed the NUM*2^20/DEN divide.
          m_d     = {quo_q[10:0], div_ge};
          mod_d   = div_rem;
          rem_d   = num_q;
          quo_d   = '0;
          step_d  = '0;
          state_d = S_DIV_H;
        end
      end

      S_DIV_H: begin
        rem_d  = div_rem;
        quo_d  = {quo_q[18:0], div_ge};
        step_d = step_q + 5'd1;
        if (step_q == H_LAST) begin
          lacc_d  = '0;
          step_d  = '0;
          state_d = S_MUL_L;
        end
      end

      S_MUL_L: begin
        // MSB-first shift-add of rh*m; partial sums never exceed the final l.
        lacc_d = {lacc_q[10:0], 1'b0} + mul_add;
        m_d    = {m_q[10:0], 1'b0};
        step_d = step_q + 5'd1;
        if (step_q == L_LAST) begin
          state_d = S_APPLY;
        end
      end

      S_APPLY: begin
        ph_h_d      = quo_q;
        ph_l_d      = lacc_q;
        modulo_d    = mod_q;
        acc_reset_d = 1'b1;
        valid_d     = 1'b0;
        cnt_d       = SETTLE_INIT;
        state_d     = S_SETTLE;
      end

      S_SETTLE: begin
        acc_reset_d = 1'b0;
        cnt_d       = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          valid_d = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign cfg_busy     = (state_q != S_IDLE);
  assign cfg_done     = done_q;
  assign cfg_err      = err_q;
  assign phase_step_h = ph_h_q;
  assign phase_step_l = ph_l_q;
  assign modulo       = modulo_q;
  assign acc_reset    = acc_reset_q;
  assign data_valid   = valid_q;

endmodule
`default_nettype wire

// File: doc/dds_cfg_ctl.md
Name: dds_cfg_ctl

Overview:
- Run-time configuration controller for the LO phase accumulator that feeds the non-IQ downconverter.
- Accepts a requested LO frequency ratio NUM/DEN and computes phase_step_h, phase_step_l and modulo with sequential shift-subtract and shift-add arithmetic.
- Applies the three values atomically, resynchronises the accumulator, then holds a downstream valid flag low for the DDC/interpolator settling time.
- Sits between the control register bank and ph_acc; its valid output gates the I/Q consumers.

Parameters:
SETTLE_CYC, 21, cycles data_valid stays low after apply (16 cycles DDC latency + 5 margin); range 1..255
SW, 8, width of settle counter; must hold SETTLE_CYC

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cfg_num  in  12  requested numerator NUM
cfg_den  in  12  requested denominator DEN
cfg_start  in  1  one-cycle request; sampled only in IDLE
cfg_busy  out  1  high from accepting edge until return to IDLE
cfg_done  out  1  one-cycle pulse when data_valid re-asserts
cfg_err  out  1  sticky; set on rejected request, cleared by next accepted request
phase_step_h  out  20  to ph_acc
phase_step_l  out  12  to ph_acc
modulo  out  12  to ph_acc
acc_reset  out  1  to ph_acc reset
data_valid  out  1  downstream I/Q data trustworthy

Behaviour:
- Reset (async, reset_n=0): state IDLE; phase_step_h/l=0, modulo=0; acc_reset=1; data_valid=0; cfg_busy=0; cfg_done=0; cfg_err=0. A reset mid-operation discards all work.
- Arithmetic, all exact integers:
  - m = floor(4096/DEN); modulo = 4096 - m*DEN
  - h = floor(NUM*2^20/DEN)
  - l = (NUM*2^20 mod DEN)*m; l always < 4096
- Legal request: 2 <= DEN <= 4095 and 0 <= NUM < DEN.
- IDLE, cfg_start=1, illegal request:
  - cfg_err=1 and cfg_busy=1 for exactly one cycle, then IDLE.
  - Outputs, acc_reset and data_valid unchanged.
- IDLE, cfg_start=1, legal request (accepting edge E0):
  - Latch NUM/DEN; cfg_busy=1; cfg_err=0.
  - The applied configuration and data_valid stay unchanged during computation.
- DIV_M, 12 cycles: restoring divide. Remainder starts at 1; shift in 12 zeros; quotient is m; final remainder is modulo.
- DIV_H, 20 cycles: restoring divide. Remainder starts at NUM; shift in 20 zeros; quotient is h, remainder rh.
- MUL_L, 12 cycles: shift-add of rh*m into a 12-bit result l.
- APPLY, 1 cycle:
  - At edge E0+45, phase_step_h/l and modulo load simultaneously.
  - acc_reset=1 for exactly that one cycle; it is 0 afterwards.
  - data_valid=0.
  - Settle counter loads SETTLE_CYC.
- SETTLE:
  - Counter decrements each cycle.
  - On the edge where it reaches 0: data_valid=1, cfg_done=1 for one cycle, cfg_busy=0, state IDLE.
  - data_valid therefore rises at E0+45+SETTLE_CYC.
- cfg_start while busy: ignored, never queued.
- cfg_start on the same edge busy falls: not accepted; a request is accepted only when sampled with state=IDLE.
- cfg_num and cfg_den may change after E0 without effect.
- acc_reset stays high from reset until the first successful APPLY.
- Rejected requests never alter data_valid.

Test Plan:
- Release reset, request NUM=4, DEN=23 -> at E0+45: h=182361, l=178, modulo=2. acc_reset pulses 1 cycle. data_valid rises at E0+66 together with cfg_done.
- Request 1/4 -> h=262144, l=0, modulo=0. Then request 7/33 -> h=222425, l=868, modulo=4. Old values are held until E0+45 of the second request, with data_valid high throughout computation.
- Request DEN=1, then NUM=23/DEN=23 -> cfg_err=1 and one-cycle busy each time; outputs and data_valid unchanged. A following legal 4/23 request clears cfg_err at its E0.
- Pulse cfg_start at E0+10 and on the cycle cfg_busy falls with different NUM/DEN -> both ignored; only the first configuration is applied. Exactly one cfg_done pulse.
- Drive reset_n low at E0+30 -> all outputs take reset values asynchronously and acc_reset=1. After release, the next request completes normally in 45+SETTLE_CYC cycles.
- SETTLE_CYC=1 build, request 4/23 -> data_valid low for exactly one cycle, at E0+45 only.
